// File: rtl/epcs_read_sequencer.sv
// EPCS serial flash bulk-read sequencer (SPI mode 0, READ 0x03).
// Streams bytes on a valid/ready port and stalls DCLK low on back-pressure.
module epcs_read_sequencer #(
    parameter int CLK_DIV = 4,
    parameter int CS_HIGH = 4,
    parameter int LEN_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [23:0]      i_cmd_addr,
    input  logic [LEN_W-1:0] i_cmd_len,
    output logic [7:0]       o_rd_data,
    output logic             o_rd_valid,
    input  logic             i_rd_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_epcs_dclk,
    output logic             o_epcs_sce,
    output logic             o_epcs_sdo,
    input  logic             i_epcs_data0
);

    localparam int CNT_MAX = (CLK_DIV > CS_HIGH) ? CLK_DIV : CS_HIGH;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [7:0] READ_CMD = 8'h03;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CSH  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dclk;
    logic             r_sce;
    logic             r_sdo;
    logic [31:0]      r_tx;
    logic [5:0]       r_bit;
    logic [LEN_W-1:0] r_len;
    logic [6:0]       r_rx;
    logic [7:0]       r_rd_data;
    logic             r_rd_valid;

    logic       w_shift;
    logic       w_edge;
    logic       w_stall;
    logic       w_rise;
    logic       w_fall;
    logic       w_take;
    logic       w_csh_end;
    logic [7:0] w_rx_byte;

    assign w_shift   = (r_state == S_CMD) || (r_state == S_ADDR)
                    || (r_state == S_DATA);
    assign w_edge    = (r_cnt == CNT_W'(CLK_DIV - 1));
    // A pending byte blocks the first rise of the next one.
    assign w_stall   = (r_state == S_DATA) && !r_dclk && (r_bit == 6'd0)
                    && r_rd_valid && !i_rd_ready;
    assign w_rise    = w_shift && w_edge && !r_dclk && !w_stall;
    assign w_fall    = w_shift && w_edge && r_dclk;
    assign w_take    = r_rd_valid && i_rd_ready;
    assign w_csh_end = (r_cnt == CNT_W'(CS_HIGH - 1));
    assign w_rx_byte = {r_rx, i_epcs_data0};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_dclk     <= 1'b0;
            r_sce      <= 1'b1;
            r_sdo      <= 1'b0;
            r_tx       <= '0;
            r_bit      <= '0;
            r_len      <= '0;
            r_rx       <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_take) begin
                r_rd_valid <= 1'b0;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        r_len  <= i_cmd_len;
                        r_tx   <= {READ_CMD, i_cmd_addr};
                        r_cnt  <= '0;
                        r_bit  <= '0;
                        r_dclk <= 1'b0;
                        if (i_cmd_len == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_CMD;
                            r_sce   <= 1'b0;
                            r_sdo   <= READ_CMD[7];
                        end
                    end
                end
                S_CMD, S_ADDR, S_DATA: begin
                    if (w_stall || w_edge) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (w_rise) begin
                        r_dclk <= 1'b1;
                        if (r_state == S_DATA) begin
                            r_rx <= w_rx_byte[6:0];
                            if (r_bit == 6'd7) begin
                                r_rd_data  <= w_rx_byte;
                                r_rd_valid <= 1'b1;
                                r_len      <= r_len - LEN_W'(1);
                                r_bit      <= '0;
                            end else begin
                                r_bit <= r_bit + 6'd1;
                            end
                        end else begin
                            r_bit <= r_bit + 6'd1;
                        end
                    end
                    if (w_fall) begin
                        r_dclk <= 1'b0;
                        r_tx   <= {r_tx[30:0], 1'b0};
                        r_sdo  <= r_tx[30];
                        if ((r_state == S_CMD) && (r_bit == 6'd8)) begin
                            r_state <= S_ADDR;
                        end
                        if ((r_state == S_ADDR) && (r_bit == 6'd32)) begin
                            r_state <= S_DATA;
                            r_bit   <= '0;
                        end
                        // Last byte captured: release chip select.
                        if ((r_state == S_DATA) && (r_len == '0)) begin
                            r_state <= S_CSH;
                            r_sce   <= 1'b1;
                            r_sdo   <= 1'b0;
                        end
                    end
                end
                S_CSH: begin
                    if (w_csh_end) begin
                        if (!r_rd_valid) begin
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready = (r_state == S_IDLE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_rd_data   = r_rd_data;
    assign o_rd_valid  = r_rd_valid;
    assign o_epcs_dclk = r_dclk;
    assign o_epcs_sce  = r_sce;
    assign o_epcs_sdo  = r_sdo;

endmodule
